// File: rtl/spi_reg_bridge.sv
// Command parser between the SPI slave byte engine and the register bus.
// Turns chip-select framed byte streams into single-cycle register write/read strobes.
module spi_reg_bridge #(
  parameter logic [7:0] STATUS_BYTE = 8'hA5,
  parameter int         RD_TIMEOUT  = 15,
  parameter logic [7:0] ERR_BYTE    = 8'hEE
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       ncs,
  input  logic       rec_flag,
  input  logic [7:0] rec_data,
  output logic [7:0] send_data,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  input  logic       reg_rd_valid,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR_W  = 3'd1,
    WDATA   = 3'd2,
    ADDR_R  = 3'd3,
    RD_WAIT = 3'd4,
    RDATA   = 3'd5,
    DISCARD = 3'd6
  } state_t;

  localparam int              CW       = $clog2(RD_TIMEOUT + 1);
  localparam logic [CW-1:0]   TMO_LAST = CW'(RD_TIMEOUT - 1);
  localparam logic [CW-1:0]   TMO_MAX  = CW'(RD_TIMEOUT);

  state_t        state, state_next;
  logic [2:0]    ncs_sync;
  logic          ncs_high;
  logic          rec_flag_d;
  logic          byte_stb;
  logic [CW-1:0] tmo_cnt;

  logic act_load_addr, act_wr, act_rd, act_err, act_rdata, act_tmo;

  // ncs only counts as deasserted once three consecutive samples agree
  assign ncs_high = &ncs_sync;
  assign byte_stb = rec_flag & ~rec_flag_d;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (ncs_high) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (byte_stb) begin
                   if (rec_data == 8'h80)      state_next = ADDR_W;
                   else if (rec_data == 8'h00) state_next = ADDR_R;
                   else                        state_next = DISCARD;
                 end
        ADDR_W:  if (byte_stb) state_next = WDATA;
        ADDR_R:  if (byte_stb) state_next = RD_WAIT;
        RD_WAIT: if (act_rdata || act_tmo) state_next = RDATA;
        RDATA:   if (byte_stb) state_next = RD_WAIT;
        default: state_next = state;
      endcase
    end
  end

  // Per-cycle actions decoded from state; abort suppresses every action
  always_comb begin
    act_load_addr = 1'b0;
    act_wr        = 1'b0;
    act_rd        = 1'b0;
    act_err       = 1'b0;
    act_rdata     = 1'b0;
    act_tmo       = 1'b0;
    busy          = (state != IDLE);
    if (!ncs_high) begin
      unique case (state)
        IDLE:    act_err = byte_stb && (rec_data != 8'h80) && (rec_data != 8'h00);
        ADDR_W:  act_load_addr = byte_stb;
        WDATA:   act_wr = byte_stb;
        ADDR_R:  begin
                   act_load_addr = byte_stb;
                   act_rd        = byte_stb;
                 end
        RD_WAIT: begin
                   if (reg_rd_valid) begin
                     act_rdata = 1'b1;
                   end else if (!reg_rd && tmo_cnt == TMO_LAST) begin
                     act_tmo = 1'b1;
                     act_err = 1'b1;
                   end
                 end
        RDATA:   act_rd = byte_stb;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ncs_sync   <= 3'b000;
      rec_flag_d <= 1'b0;
      tmo_cnt    <= '0;
      send_data  <= STATUS_BYTE;
      reg_addr   <= 8'h00;
      reg_wdata  <= 8'h00;
      reg_wr     <= 1'b0;
      reg_rd     <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      ncs_sync   <= {ncs_sync[1:0], ncs};
      rec_flag_d <= rec_flag;
      reg_wr     <= act_wr;
      reg_rd     <= act_rd;
      frame_err  <= act_err;
      if (reg_rd)                 tmo_cnt <= '0;
      else if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + 1'b1;
      if (act_wr) reg_wdata <= rec_data;
      // a write bumps the address the cycle after its strobe; reads bump on completion
      if (act_load_addr)                      reg_addr <= rec_data;
      else if (reg_wr || act_rdata || act_tmo) reg_addr <= reg_addr + 8'd1;
      if (ncs_high)       send_data <= STATUS_BYTE;
      else if (act_rdata) send_data <= reg_rdata;
      else if (act_tmo)   send_data <= ERR_BYTE;
    end
  end

endmodule
